snake_pixel_renderer: RTL and testbench

SNAKE_PIXEL_RENDERER -- requirements
Module: snake_pixel_renderer

---
 rtl/snake_pixel_renderer.sv | 194 +++++++++++++++++++
 tb/tb_snake_pixel_renderer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_pixel_renderer.sv
// Snake game pixel renderer: captures the streamed snake body into a shadow
// buffer, commits it to the display buffer only at frame start, and produces
// a 12-bit colour per pixel through a two-stage pipeline.
module snake_pixel_renderer #(
  parameter int          GAME_X0    = 10,
  parameter int          GAME_Y0    = 65,
  parameter int          CELL_PIX   = 5,
  parameter int          H_CELLS    = 124,
  parameter int          V_CELLS    = 81,
  parameter int          LEN_MAX    = 16,
  parameter int          LEN_BIT    = 5,
  parameter logic [11:0] COL_BG     = 12'h000,
  parameter logic [11:0] COL_BORDER = 12'h888,
  parameter logic [11:0] COL_HEAD   = 12'h0F0,
  parameter logic [11:0] COL_BODY   = 12'h0A0,
  parameter logic [11:0] COL_FRUIT  = 12'hF00,
  parameter logic [11:0] COL_DEAD   = 12'hF80
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               display_area,
  input  logic               frame_start,
  input  logic               en_snake_body,
  input  logic [6:0]         snake_body_x,
  input  logic [6:0]         snake_body_y,
  input  logic [6:0]         snake_head_x,
  input  logic [6:0]         snake_head_y,
  input  logic [6:0]         fruit_x,
  input  logic [6:0]         fruit_y,
  input  logic [LEN_BIT-1:0] snake_length,
  input  logic               game_over,
  output logic [11:0]        pixel_rgb
);

  localparam int AW    = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam int IW    = $clog2(LEN_MAX + 1);
  localparam int SW    = $clog2(CELL_PIX);
  localparam int X_END = GAME_X0 + H_CELLS * CELL_PIX - 1;
  localparam int Y_END = GAME_Y0 + V_CELLS * CELL_PIX - 1;
  localparam logic [6:0]         NONE      = 7'h7F;
  localparam logic [LEN_BIT-1:0] LEN_CLAMP = LEN_BIT'(LEN_MAX);

  logic                         en_d, commit_pending;
  logic [IW-1:0]                cap_idx, burst_cnt;
  logic [AW-1:0]                widx;
  logic                         can_write, burst_end, burst_ok, commit;
  logic [LEN_MAX-1:0][6:0]      shadow_x, shadow_y, shadow_nx_x, shadow_nx_y;
  logic [LEN_MAX-1:0][6:0]      pend_x, pend_y, buf_x, buf_y;
  logic [LEN_BIT-1:0]           disp_len;
  logic [6:0]                   head_xd, head_yd, fruit_xd, fruit_yd;
  logic                         over_d;
  logic [6:0]                   cell_x, cell_y;
  logic [SW-1:0]                sub_x, sub_y;
  logic                         in_game_q, display_q;
  logic                         x_in, y_in;
  logic [LEN_MAX-1:0]           body_vec;
  logic                         head_hit, fruit_hit, body_hit;

  assign widx      = cap_idx[AW-1:0];
  assign can_write = en_d && (cap_idx < IW'(LEN_MAX));
  // The burst-end clock still carries the final segment, so the length test
  // uses the count including that write.
  assign burst_cnt = cap_idx + IW'(can_write);
  assign burst_end = en_d && !en_snake_body;
  assign burst_ok  = burst_end && (int'(burst_cnt) >= int'(snake_length));
  assign commit    = frame_start && commit_pending;

  // Shadow contents after this clock's write (also the snapshot source).
  always_comb begin
    shadow_nx_x = shadow_x;
    shadow_nx_y = shadow_y;
    if (can_write) begin
      shadow_nx_x[widx] = snake_body_x;
      shadow_nx_y[widx] = snake_body_y;
    end
  end

  // Body capture, burst qualification and frame-aligned commit. A good burst
  // is snapshotted into pend_* so a commit landing on the same clock as a
  // new burst end still uses the earlier burst.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      en_d           <= 1'b0;
      cap_idx        <= '0;
      commit_pending <= 1'b0;
      shadow_x       <= {LEN_MAX{NONE}};
      shadow_y       <= {LEN_MAX{NONE}};
      pend_x         <= {LEN_MAX{NONE}};
      pend_y         <= {LEN_MAX{NONE}};
      buf_x          <= {LEN_MAX{NONE}};
      buf_y          <= {LEN_MAX{NONE}};
      disp_len       <= '0;
    end else begin
      en_d     <= en_snake_body;
      shadow_x <= shadow_nx_x;
      shadow_y <= shadow_nx_y;
      if (!en_d)          cap_idx <= '0;
      else if (can_write) cap_idx <= cap_idx + 1'b1;
      if (burst_ok) begin
        pend_x         <= shadow_nx_x;
        pend_y         <= shadow_nx_y;
        commit_pending <= 1'b1;
      end else if (commit) begin
        commit_pending <= 1'b0;
      end
      if (commit) begin
        buf_x    <= pend_x;
        buf_y    <= pend_y;
        disp_len <= (snake_length > LEN_CLAMP) ? LEN_CLAMP : snake_length;
      end
    end
  end

  // Head, fruit and game-over are frozen for the whole frame.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      head_xd  <= NONE;
      head_yd  <= NONE;
      fruit_xd <= NONE;
      fruit_yd <= NONE;
      over_d   <= 1'b0;
    end else if (frame_start) begin
      head_xd  <= snake_head_x;
      head_yd  <= snake_head_y;
      fruit_xd <= fruit_x;
      fruit_yd <= fruit_y;
      over_d   <= game_over;
    end
  end

  assign x_in = (pixel_x >= 10'(GAME_X0)) && (pixel_x <= 10'(X_END));
  assign y_in = (pixel_y >= 10'(GAME_Y0)) && (pixel_y <= 10'(Y_END));

  // Stage 1: incremental cell counters (no divider) plus area flags.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      cell_x    <= '0;
      sub_x     <= '0;
      cell_y    <= '0;
      sub_y     <= '0;
      in_game_q <= 1'b0;
      display_q <= 1'b0;
    end else begin
      if (pixel_x == 10'(GAME_X0)) begin
        cell_x <= '0;
        sub_x  <= '0;
      end else if (sub_x == SW'(CELL_PIX - 1)) begin
        sub_x  <= '0;
        cell_x <= cell_x + 1'b1;
      end else begin
        sub_x  <= sub_x + 1'b1;
      end
      if (pixel_x == 10'd0) begin
        if (pixel_y == 10'(GAME_Y0)) begin
          cell_y <= '0;
          sub_y  <= '0;
        end else if (y_in) begin
          if (sub_y == SW'(CELL_PIX - 1)) begin
            sub_y  <= '0;
            cell_y <= cell_y + 1'b1;
          end else begin
            sub_y  <= sub_y + 1'b1;
          end
        end
      end
      in_game_q <= x_in && y_in;
      display_q <= display_area;
    end
  end

  // Entries at or beyond disp_len are masked so stale shadow data never draws.
  for (genvar i = 0; i < LEN_MAX; i++) begin : g_hit
    assign body_vec[i] = (i < int'(disp_len)) &&
                         (buf_x[i] == cell_x) && (buf_y[i] == cell_y);
  end

  assign body_hit  = |body_vec;
  assign head_hit  = (head_xd == cell_x) && (head_yd == cell_y);
  assign fruit_hit = (fruit_xd == cell_x) && (fruit_yd == cell_y);

  // Stage 2: colour by priority.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset)          pixel_rgb <= 12'h000;
    else if (!display_q) pixel_rgb <= 12'h000;
    else if (!in_game_q) pixel_rgb <= COL_BORDER;
    else if (head_hit)   pixel_rgb <= over_d ? COL_DEAD : COL_HEAD;
    else if (body_hit)   pixel_rgb <= COL_BODY;
    else if (fruit_hit)  pixel_rgb <= COL_FRUIT;
    else                 pixel_rgb <= COL_BG;
  end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench for snake_pixel_renderer: bursts, frame commits, colour
// priority, area boundaries, pipeline latency and reset behaviour.
module tb_snake_pixel_renderer;
  localparam int X0 = 10;
  localparam int Y0 = 65;
  localparam logic [11:0] BG     = 12'h000;
  localparam logic [11:0] BORDER = 12'h888;
  localparam logic [11:0] HEAD   = 12'h0F0;
  localparam logic [11:0] BODY   = 12'h0A0;
  localparam logic [11:0] FRUIT  = 12'hF00;
  localparam logic [11:0] DEAD   = 12'hF80;

  logic        clock_25 = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        display_area = 1'b1, frame_start = 1'b0, en_snake_body = 1'b0;
  logic [6:0]  snake_body_x = '0, snake_body_y = '0;
  logic [6:0]  snake_head_x = '0, snake_head_y = '0, fruit_x = '0, fruit_y = '0;
  logic [4:0]  snake_length = '0;
  logic        game_over = 1'b0;
  logic [11:0] pixel_rgb;

  int checks = 0;
  int passed = 0;
  logic [6:0]  seg_x [20];
  logic [6:0]  seg_y [20];
  logic [11:0] c1, c2;

  snake_pixel_renderer dut (
    .clock_25(clock_25), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .display_area(display_area), .frame_start(frame_start),
    .en_snake_body(en_snake_body), .snake_body_x(snake_body_x),
    .snake_body_y(snake_body_y), .snake_head_x(snake_head_x),
    .snake_head_y(snake_head_y), .fruit_x(fruit_x), .fruit_y(fruit_y),
    .snake_length(snake_length), .game_over(game_over), .pixel_rgb(pixel_rgb)
  );

  always #20 clock_25 = ~clock_25;

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  // Walk rows from the top of the game area (pixel_x=0 per row), then sweep
  // the target row from GAME_X0. c1 = colour one clock after px is presented
  // (i.e. pixel px-1), c2 = colour two clocks after (pixel px).
  task automatic render(input int px, input int py,
                        output logic [11:0] r1, output logic [11:0] r2);
    if (py >= Y0)
      for (int y = Y0; y <= py; y++) begin
        pixel_x = 10'd0; pixel_y = 10'(y); tick();
      end
    pixel_y = 10'(py);
    if (px >= X0)
      for (int x = X0; x < px; x++) begin
        pixel_x = 10'(x); tick();
      end
    pixel_x = 10'(px);
    tick();
    r1 = pixel_rgb;
    pixel_x = 10'(px + 1);
    tick();
    r2 = pixel_rgb;
  endtask

  task automatic frame(input logic [6:0] hx, input logic [6:0] hy,
                       input logic [6:0] fx, input logic [6:0] fy, input logic go);
    snake_head_x = hx; snake_head_y = hy; fruit_x = fx; fruit_y = fy; game_over = go;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // en high for n clocks; segment j is presented the clock after en's j-th cycle.
  task automatic burst(input int n, input bit fs_last);
    en_snake_body = 1'b1;
    tick();
    for (int j = 1; j < n; j++) begin
      snake_body_x = seg_x[j-1]; snake_body_y = seg_y[j-1];
      tick();
    end
    en_snake_body = 1'b0;
    snake_body_x = seg_x[n-1]; snake_body_y = seg_y[n-1];
    frame_start = fs_last;
    tick();
    frame_start = 1'b0;
    snake_body_x = '0; snake_body_y = '0;
    tick();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #3;
    checks++;
    if (pixel_rgb !== 12'h000) $display("FAIL reset_rgb: got %h want %h", pixel_rgb, 12'h000);
    else passed++;
    tick(); tick();
    reset = 1'b1;
    tick();
    render(X0, Y0, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL reset_no_head: got %h want %h", c2, BG);
    else passed++;
    render(X0 - 1, Y0, c1, c2);
    checks++;
    if (c2 !== BORDER) $display("FAIL left_border: got %h want %h", c2, BORDER);
    else passed++;
    display_area = 1'b0;
    render(X0 + 5, Y0 + 5, c1, c2);
    display_area = 1'b1;
    checks++;
    if (c2 !== 12'h000) $display("FAIL blanking: got %h want %h", c2, 12'h000);
    else passed++;
  endtask

  task automatic test_body();
    for (int i = 0; i < 4; i++) begin seg_x[i] = 7'(60 - i); seg_y[i] = 7'd40; end
    snake_length = 5'd4;
    burst(4, 1'b0);
    render(X0 + 295, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL body_before_frame: got %h want %h", c2, BG);
    else passed++;
    frame(7'd61, 7'd40, 7'd10, 7'd10, 1'b0);
    render(X0 + 295, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL body_59_40: got %h want %h", c2, BODY);
    else passed++;
    render(X0 + 285, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL body_57_40: got %h want %h", c2, BODY);
    else passed++;
    checks++;
    if (c1 !== BG) $display("FAIL cell_56_40: got %h want %h", c1, BG);
    else passed++;
    render(X0 + 305, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== HEAD) $display("FAIL head_61_40: got %h want %h", c2, HEAD);
    else passed++;
    render(X0 + 295, Y0 + 205, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL cell_59_41: got %h want %h", c2, BG);
    else passed++;
    render(X0 + 50, Y0 + 50, c1, c2);
    checks++;
    if (c2 !== FRUIT) $display("FAIL fruit_10_10: got %h want %h", c2, FRUIT);
    else passed++;
  endtask

  task automatic test_short_burst();
    for (int i = 0; i < 3; i++) begin seg_x[i] = 7'(20 + i); seg_y[i] = 7'd20; end
    snake_length = 5'd5;
    burst(3, 1'b0);
    frame(7'd61, 7'd40, 7'd10, 7'd10, 1'b0);
    render(X0 + 100, Y0 + 100, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL short_not_drawn: got %h want %h", c2, BG);
    else passed++;
    render(X0 + 295, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL short_keeps_old: got %h want %h", c2, BODY);
    else passed++;
  endtask

  task automatic test_head_fruit();
    frame(7'd0, 7'd0, 7'd123, 7'd80, 1'b0);
    render(X0, Y0, c1, c2);
    checks++;
    if (c2 !== HEAD) $display("FAIL head_0_0: got %h want %h", c2, HEAD);
    else passed++;
    render(X0 + 619, Y0 + 404, c1, c2);
    checks++;
    if (c2 !== FRUIT) $display("FAIL fruit_123_80: got %h want %h", c2, FRUIT);
    else passed++;
    render(X0 + 620, Y0 + 404, c1, c2);
    checks++;
    if (c1 !== FRUIT) $display("FAIL latency_prev_pixel: got %h want %h", c1, FRUIT);
    else passed++;
    checks++;
    if (c2 !== BORDER) $display("FAIL latency_border: got %h want %h", c2, BORDER);
    else passed++;
    render(X0 + 620, Y0, c1, c2);
    checks++;
    if (c2 !== BORDER) $display("FAIL right_border: got %h want %h", c2, BORDER);
    else passed++;
    render(X0 + 619, Y0 + 405, c1, c2);
    checks++;
    if (c2 !== BORDER) $display("FAIL bottom_border: got %h want %h", c2, BORDER);
    else passed++;
  endtask

  task automatic test_overlap();
    frame(7'd30, 7'd30, 7'd30, 7'd30, 1'b0);
    render(X0 + 150, Y0 + 150, c1, c2);
    checks++;
    if (c2 !== HEAD) $display("FAIL head_over_fruit: got %h want %h", c2, HEAD);
    else passed++;
    frame(7'd30, 7'd30, 7'd30, 7'd30, 1'b1);
    render(X0 + 150, Y0 + 150, c1, c2);
    checks++;
    if (c2 !== DEAD) $display("FAIL dead_head: got %h want %h", c2, DEAD);
    else passed++;
  endtask

  task automatic test_back_to_back();
    snake_head_x = 7'd1; snake_head_y = 7'd1; fruit_x = 7'd2; fruit_y = 7'd2;
    game_over = 1'b0;
    seg_x[0] = 7'd5; seg_y[0] = 7'd5; seg_x[1] = 7'd6; seg_y[1] = 7'd5;
    snake_length = 5'd2;
    burst(2, 1'b1);
    render(X0 + 25, Y0 + 25, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL coincide_new_hidden: got %h want %h", c2, BG);
    else passed++;
    render(X0 + 295, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL coincide_old_shown: got %h want %h", c2, BODY);
    else passed++;
    frame(7'd1, 7'd1, 7'd2, 7'd2, 1'b0);
    render(X0 + 25, Y0 + 25, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL next_frame_new: got %h want %h", c2, BODY);
    else passed++;
    render(X0 + 295, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL next_frame_old_gone: got %h want %h", c2, BG);
    else passed++;
    // pending burst A, then burst B ending on a frame: A shows, then B
    seg_x[0] = 7'd100; seg_y[0] = 7'd70; snake_length = 5'd1;
    burst(1, 1'b0);
    seg_x[0] = 7'd101;
    burst(1, 1'b1);
    render(X0 + 500, Y0 + 350, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL pend_a_shown: got %h want %h", c2, BODY);
    else passed++;
    render(X0 + 505, Y0 + 350, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL pend_b_hidden: got %h want %h", c2, BG);
    else passed++;
    frame(7'd1, 7'd1, 7'd2, 7'd2, 1'b0);
    render(X0 + 505, Y0 + 350, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL pend_b_shown: got %h want %h", c2, BODY);
    else passed++;
  endtask

  task automatic test_boundaries();
    seg_x[0] = 7'd40; seg_y[0] = 7'd50; snake_length = 5'd0;
    burst(1, 1'b0);
    frame(7'd1, 7'd1, 7'd2, 7'd2, 1'b0);
    render(X0 + 200, Y0 + 250, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL len0_no_body: got %h want %h", c2, BG);
    else passed++;
    render(X0 + 505, Y0 + 350, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL len0_old_gone: got %h want %h", c2, BG);
    else passed++;
    for (int i = 0; i < 17; i++) begin seg_x[i] = 7'(i); seg_y[i] = 7'd60; end
    snake_length = 5'd16;
    burst(17, 1'b0);
    snake_length = 5'd20;
    frame(7'd1, 7'd1, 7'd2, 7'd2, 1'b0);
    render(X0, Y0 + 300, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL clamp_seg0: got %h want %h", c2, BODY);
    else passed++;
    render(X0 + 75, Y0 + 300, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL clamp_seg15: got %h want %h", c2, BODY);
    else passed++;
    render(X0 + 80, Y0 + 300, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL saturate_drop: got %h want %h", c2, BG);
    else passed++;
  endtask

  task automatic test_reset_mid();
    seg_x[0] = 7'd59; seg_y[0] = 7'd40; snake_length = 5'd1;
    burst(1, 1'b0);
    en_snake_body = 1'b1;
    tick();
    snake_body_x = 7'd70; snake_body_y = 7'd70;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (pixel_rgb !== 12'h000) $display("FAIL reset_mid_rgb: got %h want %h", pixel_rgb, 12'h000);
    else passed++;
    en_snake_body = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    render(X0 + 295, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL reset_pending_cleared: got %h want %h", c2, BG);
    else passed++;
    render(X0 + 350, Y0 + 350, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL reset_burst_lost: got %h want %h", c2, BG);
    else passed++;
    render(X0 + 75, Y0 + 300, c1, c2);
    checks++;
    if (c2 !== BG) $display("FAIL reset_display_cleared: got %h want %h", c2, BG);
    else passed++;
    burst(1, 1'b0);
    frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    render(X0 + 295, Y0 + 200, c1, c2);
    checks++;
    if (c2 !== BODY) $display("FAIL post_reset_commit: got %h want %h", c2, BODY);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_body();
    test_short_burst();
    test_head_fruit();
    test_overlap();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
